line_burst_adaptor: RTL and testbench



---
 rtl/line_burst_adaptor_if.sv | 26 ++
 rtl/line_burst_adaptor.sv | 94 +++++++++
 tb/tb_line_burst_adaptor.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_burst_adaptor_if.sv
// Signal bundle between main_cache, the line/burst adaptor and burst physical memory.
// The slave modport is the adaptor's view; master is the surrounding environment.
interface line_burst_adaptor_if;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/line_burst_adaptor.sv
// Converts 256-bit cache line fills/writebacks into four 64-bit memory bursts.
// state  | meaning
// IDLE   | waiting for a cache read/write request (write wins)
// READ   | collecting four read beats into the line buffer
// WRITE  | presenting four write beats from the line buffer
// DONE   | one-cycle completion pulse back to the cache
module line_burst_adaptor (
    input  logic                  clk,
    input  logic                  rst,
    line_burst_adaptor_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    logic [1:0]     r_k;
    logic [255:0]   r_buf;
    logic [31:0]    r_addr;
    logic           r_read_o;
    logic           r_write_o;
    logic           r_resp_o;
    logic [7:0]     w_beat_lsb;

    assign w_beat_lsb = {r_k, 6'd0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= 2'd0;
            r_buf     <= '0;
            r_addr    <= '0;
            r_read_o  <= 1'b0;
            r_write_o <= 1'b0;
            r_resp_o  <= 1'b0;
        end else begin
            r_resp_o <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.write_i) begin
                        r_addr    <= {bus.address_i[31:5], 5'd0};
                        r_buf     <= bus.line_i;
                        r_k       <= 2'd0;
                        r_write_o <= 1'b1;
                        r_state   <= S_WRITE;
                    end else if (bus.read_i) begin
                        r_addr   <= {bus.address_i[31:5], 5'd0};
                        r_k      <= 2'd0;
                        r_read_o <= 1'b1;
                        r_state  <= S_READ;
                    end
                end
                S_READ: begin
                    if (bus.resp_i) begin
                        r_buf[w_beat_lsb +: 64] <= bus.burst_i;
                        r_k <= r_k + 2'd1;
                        if (r_k == 2'd3) begin
                            r_read_o <= 1'b0;
                            r_resp_o <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.resp_i) begin
                        r_k <= r_k + 2'd1;
                        if (r_k == 2'd3) begin
                            r_write_o <= 1'b0;
                            r_resp_o  <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write data follows the beat counter directly so a new beat appears the cycle after each ack.
    assign bus.burst_o   = r_buf[w_beat_lsb +: 64];
    assign bus.line_o    = r_buf;
    assign bus.address_o = r_addr;
    assign bus.read_o    = r_read_o;
    assign bus.write_o   = r_write_o;
    assign bus.resp_o    = r_resp_o;
endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed and randomized checks of line_burst_adaptor against a word-array line model.
module tb_line_burst_adaptor;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    logic [63:0] m_w [4];
    logic [31:0] m_addr;
    logic [63:0] src [4];

    always #5 clk = ~clk;

    line_burst_adaptor_if bus ();

    line_burst_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [255:0] m_line();
        return {m_w[3], m_w[2], m_w[1], m_w[0]};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_read_o"},  bus.read_o,    1'b0);
        chk({tag, "_write_o"}, bus.write_o,   1'b0);
        chk({tag, "_resp_o"},  bus.resp_o,    1'b0);
        chk({tag, "_line_o"},  bus.line_o,    m_line());
        chk({tag, "_addr_o"},  bus.address_o, m_addr);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_w[i] = '0;
        m_addr = '0;
    endtask

    // Present a request for one edge; optionally keep read_i asserted afterwards.
    task automatic accept(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [255:0] l, input bit hold_rd);
        bus.read_i    = rd;
        bus.write_i   = wr;
        bus.address_i = a;
        bus.line_i    = l;
        tick();
        bus.read_i  = hold_rd;
        bus.write_i = 1'b0;
        bus.line_i  = {8{$urandom}};
        m_addr = {a[31:5], 5'd0};
        if (wr) for (int i = 0; i < 4; i++) m_w[i] = l[64*i +: 64];
    endtask

    function automatic bit pick_ack(input logic [15:0] pat, input int plen, input int cyc);
        if (cyc < plen) return pat[cyc];
        if (plen > 0 || cyc >= 16) return 1'b1;
        return ($urandom_range(0, 2) != 0);
    endfunction

    task automatic read_phase(input logic [15:0] pat, input int plen);
        int n = 0;
        int cyc = 0;
        bit ack;
        while (n < 4 && cyc < 64) begin
            chk("rd_read_o",  bus.read_o,    1'b1);
            chk("rd_write_o", bus.write_o,   1'b0);
            chk("rd_resp_o",  bus.resp_o,    1'b0);
            chk("rd_addr_o",  bus.address_o, m_addr);
            chk("rd_line_o",  bus.line_o,    m_line());
            ack = pick_ack(pat, plen, cyc);
            bus.resp_i  = ack;
            bus.burst_i = ack ? src[n] : {$urandom, $urandom};
            tick();
            if (ack) begin
                m_w[n] = src[n];
                n++;
            end
            cyc++;
        end
        bus.resp_i = 1'b0;
        chk("rd_beat_count", n, 4);
        chk("rd_done_resp_o",  bus.resp_o,  1'b1);
        chk("rd_done_read_o",  bus.read_o,  1'b0);
        chk("rd_done_write_o", bus.write_o, 1'b0);
        chk("rd_done_line_o",  bus.line_o,  m_line());
        chk("rd_done_addr_o",  bus.address_o, m_addr);
    endtask

    task automatic write_phase(input logic [15:0] pat, input int plen);
        int n = 0;
        int cyc = 0;
        bit ack;
        while (n < 4 && cyc < 64) begin
            chk("wr_write_o", bus.write_o,   1'b1);
            chk("wr_read_o",  bus.read_o,    1'b0);
            chk("wr_resp_o",  bus.resp_o,    1'b0);
            chk("wr_addr_o",  bus.address_o, m_addr);
            chk("wr_burst_o", bus.burst_o,   m_w[n]);
            ack = pick_ack(pat, plen, cyc);
            bus.resp_i  = ack;
            bus.burst_i = {$urandom, $urandom};
            tick();
            if (ack) n++;
            cyc++;
        end
        bus.resp_i = 1'b0;
        chk("wr_beat_count", n, 4);
        chk("wr_done_resp_o",  bus.resp_o,  1'b1);
        chk("wr_done_write_o", bus.write_o, 1'b0);
        chk("wr_done_read_o",  bus.read_o,  1'b0);
    endtask

    initial begin
        logic [255:0] l;
        logic [31:0]  a;

        bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
        bus.burst_i = '0; bus.resp_i = 1'b0;
        model_reset();

        // Reset held with a pending read: nothing reaches memory.
        rst = 1'b1;
        bus.read_i = 1'b1;
        tick(); check_idle("rst1");
        chk("rst1_burst_o", bus.burst_o, 64'd0);
        tick(); check_idle("rst2");
        rst = 1'b0;
        bus.read_i = 1'b0;
        tick(); check_idle("post_rst");

        // Directed fill with four back-to-back beats.
        src[0] = {16{4'h1}}; src[1] = {16{4'h2}}; src[2] = {16{4'h3}}; src[3] = {16{4'h4}};
        accept(1'b1, 1'b0, 32'h0000_1234, '0, 1'b0);
        chk("fill_addr", bus.address_o, 32'h0000_1220);
        read_phase(16'hffff, 4);
        chk("fill_line", bus.line_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        tick(); check_idle("fill_idle");

        // Writeback with ack gaps 1,0,0,1,1,0,1.
        l = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
             64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
        accept(1'b0, 1'b1, 32'h8000_00ff, l, 1'b0);
        chk("wb_line_loaded", bus.line_o, l);
        write_phase(16'b0000_0000_0101_1001, 7);
        tick(); check_idle("wb_idle");

        // Both requests at once: write wins.
        l = {8{$urandom}};
        accept(1'b1, 1'b1, 32'h0000_4040, l, 1'b0);
        write_phase(16'h0, 0);
        tick(); check_idle("both_idle");

        // Reset after two read beats.
        for (int i = 0; i < 4; i++) src[i] = {$urandom, $urandom};
        accept(1'b1, 1'b0, 32'h0000_7777, '0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("abort_read_o", bus.read_o, 1'b1);
            bus.resp_i = 1'b1; bus.burst_i = src[i];
            tick();
            m_w[i] = src[i];
        end
        chk("abort_partial_line", bus.line_o, m_line());
        rst = 1'b1; bus.resp_i = 1'b0;
        tick();
        model_reset();
        check_idle("abort_rst");
        rst = 1'b0;
        tick(); check_idle("abort_after1");
        tick(); check_idle("abort_after2");
        for (int i = 0; i < 4; i++) src[i] = {$urandom, $urandom};
        accept(1'b1, 1'b0, 32'h0000_9999, '0, 1'b0);
        read_phase(16'hffff, 4);
        tick(); check_idle("refill_idle");

        // Back-to-back: read held high through a writeback.
        l = {8{$urandom}};
        accept(1'b1, 1'b1, 32'h0001_0000, l, 1'b1);
        write_phase(16'h0, 0);
        bus.address_i = 32'h0002_0031;
        tick();
        check_idle("b2b_idle");
        for (int i = 0; i < 4; i++) src[i] = {$urandom, $urandom};
        tick();
        bus.read_i = 1'b0;
        m_addr = 32'h0002_0020;
        read_phase(16'h0, 0);
        tick(); check_idle("b2b_done_idle");

        // Randomized transactions with random ack gaps.
        for (int t = 0; t < 12; t++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                l = {8{$urandom}};
                accept(1'b0, 1'b1, a, l, 1'b0);
                write_phase(16'h0, 0);
            end else begin
                for (int i = 0; i < 4; i++) src[i] = {$urandom, $urandom};
                accept(1'b1, 1'b0, a, '0, 1'b0);
                read_phase(16'h0, 0);
            end
            tick(); check_idle("rand_idle");
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                bus.resp_i = $urandom_range(0, 1);
                tick(); check_idle("rand_gap");
            end
            bus.resp_i = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
